// File: rtl/sw_pkg.sv
// Shared definitions for the egress switch path: header layout, default
// length width, arbiter FSM states and port count.
package sw_pkg;

  localparam int unsigned NUM_PORTS   = 2;
  localparam int unsigned LEN_W_DEF   = 16;
  // Frame length sits in the low bits of the header word.
  localparam int unsigned HDR_LEN_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. Grant is combinational from the current
// requests and the remembered last winner; the winner is recorded only when
// the owner of the port signals completion through the update strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetN,
  input  logic       req0,
  input  logic       req1,
  input  logic       update,
  input  logic       upd_port,
  output logic [1:0] gnt
);

  // 0 = port 0 won last, 1 = port 1 won last
  logic last_gnt;

  // Remember the port that just finished so a tie favours the other one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_gnt <= 1'b1;
    end else if (update) begin
      last_gnt <= upd_port;
    end
  end

  // One-hot grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    gnt = '0;
    if (req0 && req1) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/egress_arbiter.sv
// Merges frames from two ingress FIFOs onto one egress stream. A port is
// granted for a whole frame; each word takes a READ / LOAD / SEND pass, so
// the output carries at most one word every three cycles.
module egress_arbiter
  import sw_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        empty0,
  input  logic        empty1,
  input  logic [31:0] dout0,
  input  logic [31:0] dout1,
  output logic        rd_en0,
  output logic        rd_en1,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] frames_sent
);

  state_t           state;
  state_t           state_nxt;
  logic             gsel;        // granted port for the current frame
  logic [1:0]       arb_gnt;
  logic             frame_done;
  logic [LEN_W-1:0] remaining;   // words still to send after the one in SEND
  logic             sof_q;       // word in flight is the header
  logic             g_empty;
  logic [31:0]      g_dout;
  logic [LEN_W-1:0] hdr_len;

  assign g_empty = gsel ? empty1 : empty0;
  assign g_dout  = gsel ? dout1  : dout0;
  assign hdr_len = g_dout[HDR_LEN_LSB +: LEN_W];

  rr_arb2 u_arb (
    .clk      (clk),
    .resetN   (resetN),
    .req0     (!empty0),
    .req1     (!empty1),
    .update   (frame_done),
    .upd_port (gsel),
    .gnt      (arb_gnt)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and read strobes; a read is issued only when the granted FIFO has data.
  always_comb begin
    state_nxt  = state;
    rd_en0     = 1'b0;
    rd_en1     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (|arb_gnt) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (!g_empty) begin
          rd_en0    = !gsel;
          rd_en1    = gsel;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (remaining == '0) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, word counter, output word register and frame counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gsel        <= 1'b0;
      sof_q       <= 1'b0;
      remaining   <= '0;
      out_data    <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            gsel  <= arb_gnt[1];
            sof_q <= 1'b1;
          end
        end
        LOAD: begin
          out_data <= g_dout;
          if (sof_q) begin
            // a zero length field still describes a header-only frame
            remaining <= (hdr_len == '0) ? '0 : hdr_len - LEN_W'(1);
          end else begin
            remaining <= remaining - LEN_W'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            sof_q <= 1'b0;
          end
          if (frame_done) begin
            frames_sent <= frames_sent + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == SEND);
  assign out_sof   = out_valid && sof_q;
  assign out_eof   = out_valid && (remaining == '0);

endmodule

// File: tb/tb_egress_arbiter.sv
// Bench for egress_arbiter: two behavioural FIFOs feed the DUT, expected
// egress words are queued as frames are loaded and compared on handshake.
module tb_egress_arbiter;
  import sw_pkg::*;

  logic        clk;
  logic        resetN;
  logic        empty0, empty1;
  logic [31:0] dout0, dout1;
  logic        rd_en0, rd_en1;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof, out_eof;
  logic [15:0] frames_sent;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } sb_t;

  sb_t         sb[$];
  sb_t         e_m;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_frames;
  int unsigned rd1_cnt = 0;
  int unsigned snap;

  logic [31:0] mem0[256];
  logic [31:0] mem1[256];
  int unsigned wp0, wp1, rp0, rp1;

  egress_arbiter #(.LEN_W(16)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .empty0      (empty0),
    .empty1      (empty1),
    .dout0       (dout0),
    .dout1       (dout1),
    .rd_en0      (rd_en0),
    .rd_en1      (rd_en1),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  // FIFO read side: data appears the cycle after the strobe.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rp0   <= 0;
      rp1   <= 0;
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      if (rd_en0) begin
        dout0 <= mem0[rp0 % 256];
        rp0   <= rp0 + 1;
      end
      if (rd_en1) begin
        dout1 <= mem1[rp1 % 256];
        rp1   <= rp1 + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: protocol rules every cycle, scoreboard compare on each accepted word.
  always @(negedge clk) begin
    if (!resetN) begin
      sb.delete();
    end else begin
      check("rd_excl", 32'(rd_en0 & rd_en1), 32'd0);
      if (out_valid) check("rd_in_send", 32'(rd_en0 | rd_en1), 32'd0);
      if (rd_en0) check("rd0_empty", 32'(empty0), 32'd0);
      if (rd_en1) begin
        check("rd1_empty", 32'(empty1), 32'd0);
        rd1_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e_m = sb.pop_front();
          check("data", out_data, e_m.data);
          check("sof", 32'(out_sof), 32'(e_m.sof));
          check("eof", 32'(out_eof), 32'(e_m.eof));
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fifo_put(input int unsigned port, input logic [31:0] w);
    if (port == 0) begin
      mem0[wp0 % 256] = w;
      wp0++;
    end else begin
      mem1[wp1 % 256] = w;
      wp1++;
    end
  endtask

  // Queue expected words for a frame; only the first nload words enter the FIFO.
  task automatic frame(input int unsigned port, input logic [15:0] len,
                       input logic [15:0] tag, input int unsigned nload);
    int unsigned n;
    sb_t         e;
    n = (len == 16'd0) ? 1 : int'(len);
    for (int unsigned i = 0; i < n; i++) begin
      e.data = (i == 0) ? {tag, len} : {tag, 16'(i)};
      e.sof  = (i == 0);
      e.eof  = (i == n - 1);
      sb.push_back(e);
      if (i < nload) fifo_put(port, e.data);
    end
  endtask

  task automatic wait_drain(input int unsigned max);
    int unsigned n = 0;
    while (sb.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    tick(2);
  endtask

  task automatic wait_valid(input int unsigned max);
    int unsigned n = 0;
    while (!out_valid && n < max) begin
      tick(1);
      n++;
    end
    check("valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset;
    resetN     = 1'b0;
    wp0        = 0;
    wp1        = 0;
    exp_frames = 0;
    tick(2);
    resetN = 1'b1;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    resetN     = 1'b0;
    out_ready  = 1'b1;
    wp0        = 0;
    wp1        = 0;
    exp_frames = 0;
    tick(2);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sof", 32'(out_sof), 32'd0);
    check("rst_eof", 32'(out_eof), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_rd0", 32'(rd_en0), 32'd0);
    check("rst_rd1", 32'(rd_en1), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    resetN = 1'b1;
    tick(1);

    // single frame on port 0, port 1 idle
    snap = rd1_cnt;
    frame(0, 16'd3, 16'h1111, 3);
    exp_frames += 1;
    wait_drain(100);
    check("t1_frames", 32'(frames_sent), 32'(exp_frames));
    check("t1_rd1", rd1_cnt - snap, 32'd0);

    // both ports loaded right after reset: port 0 first, then port 1 in full
    do_reset();
    frame(0, 16'd2, 16'h2A2A, 2);
    frame(1, 16'd2, 16'h2B2B, 2);
    exp_frames += 2;
    wait_drain(100);
    check("t2_frames", 32'(frames_sent), 32'(exp_frames));

    // zero length header on port 1
    frame(1, 16'd0, 16'h3333, 1);
    exp_frames += 1;
    wait_drain(50);
    check("t3_frames", 32'(frames_sent), 32'(exp_frames));
    check("t3_state", 32'(dut.state), 32'(IDLE));

    // sink backpressure during SEND
    out_ready = 1'b0;
    frame(0, 16'd2, 16'h4444, 2);
    exp_frames += 1;
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, {16'h4444, 16'd2});
      check("bp_rd", 32'(rd_en0 | rd_en1), 32'd0);
    end
    out_ready = 1'b1;
    wait_drain(50);
    check("t4_frames", 32'(frames_sent), 32'(exp_frames));

    // mid-frame stall: FIFO 0 runs dry after two words
    frame(0, 16'd4, 16'h5555, 2);
    exp_frames += 1;
    n = 0;
    while (sb.size() > 2 && n < 50) begin
      tick(1);
      n++;
    end
    check("stall_reach", 32'(sb.size()), 32'd2);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("stall_state", 32'(dut.state), 32'(READ));
      check("stall_rd0", 32'(rd_en0), 32'd0);
    end
    fifo_put(0, {16'h5555, 16'd2});
    fifo_put(0, {16'h5555, 16'd3});
    wait_drain(50);
    check("t5_frames", 32'(frames_sent), 32'(exp_frames));

    // reset while a header waits in SEND
    out_ready = 1'b0;
    frame(0, 16'd4, 16'h6666, 4);
    wait_valid(20);
    resetN = 1'b0;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_sof", 32'(out_sof), 32'd0);
    check("mr_eof", 32'(out_eof), 32'd0);
    check("mr_data", out_data, 32'd0);
    check("mr_rd", 32'(rd_en0 | rd_en1), 32'd0);
    check("mr_frames", 32'(frames_sent), 32'd0);
    check("mr_state", 32'(dut.state), 32'(IDLE));
    wp0        = 0;
    wp1        = 0;
    exp_frames = 0;
    tick(2);
    resetN    = 1'b1;
    out_ready = 1'b1;
    tick(1);
    frame(1, 16'd2, 16'h7777, 2);
    exp_frames += 1;
    wait_drain(50);
    check("t6_frames", 32'(frames_sent), 32'(exp_frames));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
